// File: rtl/cordic_rot_iter_pkg.sv
// ============================================================================
// cordic_rot_iter_pkg
// Shared definitions for the iterative CORDIC rotator: FSM state codes,
// quadrant post-rotation codes, fixed-point scaling rules, gain constant
// and the arctangent table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_rot_iter_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Quadrant post-rotation codes
    localparam logic [1:0] QUAD_NONE = 2'b00;
    localparam logic [1:0] QUAD_P90  = 2'b01;
    localparam logic [1:0] QUAD_180  = 2'b10;
    localparam logic [1:0] QUAD_M90  = 2'b11;

    // Inputs are sign-extended by HEAD_BITS and given GUARD_BITS fraction bits
    localparam int HEAD_BITS  = 2;
    localparam int GUARD_BITS = 4;

    // CORDIC gain compensation 0.607253 in Q.30; narrowed to the datapath
    // fraction width by a right shift where it is used
    localparam logic [63:0] K_Q30 = 64'd652032945;

    // atan(2^-i) in datapath units where pi == 2^19, i.e. a 16-bit angle
    // (pi == 2^15) carrying 4 guard fraction bits. Beyond the table the
    // angle step is below one LSB and reads as zero.
    function automatic logic [31:0] atan_lut(input logic [31:0] i);
        case (i)
            32'd0:   atan_lut = 32'd131072;
            32'd1:   atan_lut = 32'd77376;
            32'd2:   atan_lut = 32'd40884;
            32'd3:   atan_lut = 32'd20753;
            32'd4:   atan_lut = 32'd10417;
            32'd5:   atan_lut = 32'd5213;
            32'd6:   atan_lut = 32'd2607;
            32'd7:   atan_lut = 32'd1304;
            32'd8:   atan_lut = 32'd652;
            32'd9:   atan_lut = 32'd326;
            32'd10:  atan_lut = 32'd163;
            32'd11:  atan_lut = 32'd81;
            32'd12:  atan_lut = 32'd41;
            32'd13:  atan_lut = 32'd20;
            32'd14:  atan_lut = 32'd10;
            32'd15:  atan_lut = 32'd5;
            default: atan_lut = 32'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_rot_iter_atan_rom.sv
// ============================================================================
// cordic_rot_iter_atan_rom
// Combinational micro-rotation index -> atan(2^-i) lookup, datapath wide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_rot_iter_atan_rom
    import cordic_rot_iter_pkg::*;
#(
    parameter int CORDIC_WIDTH = 22,
    parameter int IDX_WIDTH    = 4
)(
    input  logic [IDX_WIDTH-1:0]    idx,
    output logic [CORDIC_WIDTH-1:0] atan
);

    // Table read; all entries are positive so truncation keeps the value
    always_comb begin
        atan = CORDIC_WIDTH'(atan_lut(32'(idx)));
    end

endmodule

`default_nettype wire

// File: rtl/cordic_rot_iter.sv
// ============================================================================
// cordic_rot_iter
// Iterative CORDIC rotation-mode responder: one micro-rotation per clock,
// gain compensation, quadrant post-rotation, rounding and saturation.
// One request in flight; collisions and unqualified ext requests set err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_rot_iter
    import cordic_rot_iter_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_WIDTH  = 22,
    parameter int CORDIC_STAGES = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cordic_rot_en,
    input  logic [DATA_WIDTH-1:0]    cordic_rot_xin,
    input  logic [DATA_WIDTH-1:0]    cordic_rot_yin,
    input  logic                     cordic_rot_angle_microRot_n,
    input  logic [ANGLE_WIDTH-1:0]   cordic_rot_angle_in,
    input  logic [CORDIC_STAGES-1:0] cordic_rot_microRot_ext_in,
    input  logic                     cordic_rot_microRot_ext_vld,
    input  logic [1:0]               cordic_rot_quad_in,
    output logic                     cordic_rot_busy,
    output logic                     cordic_rot_opvld,
    output logic [DATA_WIDTH-1:0]    cordic_rot_xout,
    output logic [DATA_WIDTH-1:0]    cordic_rot_yout,
    output logic                     cordic_rot_err
);

    localparam int STG_W = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;
    localparam int OW    = CORDIC_WIDTH + 1;   // one extra bit so negation cannot wrap
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(CORDIC_STAGES - 1);
    localparam logic signed [CORDIC_WIDTH-1:0] K_CONST =
        CORDIC_WIDTH'(K_Q30 >> (30 - (CORDIC_WIDTH - 2)));
    localparam logic signed [OW-1:0] HALF_LSB = OW'(1) << (GUARD_BITS - 1);
    localparam logic signed [OW-1:0] SAT_MAX =
        {{(OW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_MIN =
        {{(OW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                      state;
    logic [STG_W-1:0]                cnt;
    logic signed [CORDIC_WIDTH-1:0]  x_acc, y_acc, z_acc;
    logic [CORDIC_STAGES-1:0]        ext_dirs;
    logic                            use_angle;
    logic [1:0]                      quad;

    logic                            accept;
    logic                            dir_ccw;
    logic [CORDIC_WIDTH-1:0]         atan_i;
    logic signed [CORDIC_WIDTH-1:0]  x_shift, y_shift;
    logic signed [2*CORDIC_WIDTH-1:0] prod_x, prod_y;
    logic signed [CORDIC_WIDTH-1:0]  x_scaled, y_scaled;
    logic signed [OW-1:0]            x_wide, y_wide, x_quad, y_quad;

    // Round half-up, drop guard bits, clamp to the output range
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [OW-1:0] v);
        logic signed [OW-1:0] sum;
        logic signed [OW-1:0] shr;
        sum = v + HALF_LSB;
        shr = sum >>> GUARD_BITS;
        if (shr > SAT_MAX)
            round_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shr < SAT_MIN)
            round_sat = SAT_MIN[DATA_WIDTH-1:0];
        else
            round_sat = shr[DATA_WIDTH-1:0];
    endfunction

    cordic_rot_iter_atan_rom #(
        .CORDIC_WIDTH (CORDIC_WIDTH),
        .IDX_WIDTH    (STG_W)
    ) u_atan_rom (
        .idx  (cnt),
        .atan (atan_i)
    );

    assign cordic_rot_busy = (state != ST_IDLE);
    assign accept = (state == ST_IDLE) && cordic_rot_en &&
                    (cordic_rot_angle_microRot_n || cordic_rot_microRot_ext_vld);

    // Micro-rotation direction, shifted cross terms and gain-compensated products
    always_comb begin
        dir_ccw  = use_angle ? ~z_acc[CORDIC_WIDTH-1] : ext_dirs[cnt];
        x_shift  = x_acc >>> cnt;
        y_shift  = y_acc >>> cnt;
        prod_x   = x_acc * K_CONST;
        prod_y   = y_acc * K_CONST;
        x_scaled = CORDIC_WIDTH'(prod_x >>> (CORDIC_WIDTH - 2));
        y_scaled = CORDIC_WIDTH'(prod_y >>> (CORDIC_WIDTH - 2));
    end

    // Quadrant post-rotation in the widened domain
    always_comb begin
        x_wide = {x_acc[CORDIC_WIDTH-1], x_acc};
        y_wide = {y_acc[CORDIC_WIDTH-1], y_acc};
        case (quad)
            QUAD_P90: begin x_quad = -y_wide; y_quad =  x_wide; end
            QUAD_180: begin x_quad = -x_wide; y_quad = -y_wide; end
            QUAD_M90: begin x_quad =  y_wide; y_quad = -x_wide; end
            default:  begin x_quad =  x_wide; y_quad =  y_wide; end
        endcase
    end

    // Control: state sequencing, stage count, sticky error, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            cordic_rot_err   <= 1'b0;
            cordic_rot_opvld <= 1'b0;
            cordic_rot_xout  <= '0;
            cordic_rot_yout  <= '0;
        end else begin
            cordic_rot_opvld <= 1'b0;
            if (cordic_rot_en && !accept)
                cordic_rot_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_ITER;
                        cnt   <= '0;
                    end
                end
                ST_ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STAGE)
                        state <= ST_SCALE;
                end
                ST_SCALE: begin
                    state <= ST_OUT;
                end
                default: begin
                    cordic_rot_xout  <= round_sat(x_quad);
                    cordic_rot_yout  <= round_sat(y_quad);
                    cordic_rot_opvld <= 1'b1;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: load on accept, rotate during ITER, scale by K in SCALE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_acc     <= '0;
            y_acc     <= '0;
            z_acc     <= '0;
            ext_dirs  <= '0;
            use_angle <= 1'b0;
            quad      <= QUAD_NONE;
        end else if (accept) begin
            x_acc     <= {{HEAD_BITS{cordic_rot_xin[DATA_WIDTH-1]}}, cordic_rot_xin, {GUARD_BITS{1'b0}}};
            y_acc     <= {{HEAD_BITS{cordic_rot_yin[DATA_WIDTH-1]}}, cordic_rot_yin, {GUARD_BITS{1'b0}}};
            z_acc     <= {{HEAD_BITS{cordic_rot_angle_in[ANGLE_WIDTH-1]}}, cordic_rot_angle_in, {GUARD_BITS{1'b0}}};
            ext_dirs  <= cordic_rot_microRot_ext_in;
            use_angle <= cordic_rot_angle_microRot_n;
            quad      <= cordic_rot_quad_in;
        end else if (state == ST_ITER) begin
            if (dir_ccw) begin
                x_acc <= x_acc - y_shift;
                y_acc <= y_acc + x_shift;
                z_acc <= z_acc - $signed(atan_i);
            end else begin
                x_acc <= x_acc + y_shift;
                y_acc <= y_acc - x_shift;
                z_acc <= z_acc + $signed(atan_i);
            end
        end else if (state == ST_SCALE) begin
            x_acc <= x_scaled;
            y_acc <= y_scaled;
        end
    end

endmodule

`default_nettype wire
